// File: rtl/fetch_exec_controller_pkg.sv
// Shared types and constants for the fetch/execute controller:
// opcodes, FSM state encoding, ALU selects and instruction field positions.
package fetch_exec_controller_pkg;

  localparam int IR_W    = 16;
  localparam int DADDR_W = 8;
  localparam int RADDR_W = 4;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  // The encoding is visible on state_out, so the values are fixed.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_PRIME  = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_STORE  = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam int OPC_LSB     = 12;
  localparam int RA_LSB      = 8;
  localparam int RB_LSB      = 4;
  localparam int RW_LSB      = 0;
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_LSB = 0;

  // Undefined opcodes fold onto NOOP so the FSM never sees them.
  function automatic opcode_e to_opcode(input logic [3:0] raw);
    case (raw)
      4'h1:    return OP_STORE;
      4'h2:    return OP_LOAD;
      4'h3:    return OP_ADD;
      4'h4:    return OP_SUB;
      4'h5:    return OP_HALT;
      default: return OP_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/fetch_exec_controller_if.sv
// Control bus between the sequencer and the fetch/execute datapath.
// master = controller side, slave = datapath side.
interface fetch_exec_controller_if;
  import fetch_exec_controller_pkg::*;

  logic [IR_W-1:0]    IR;
  logic               PC_clr;
  logic               PC_up;
  logic               IR_ld;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RADDR_W-1:0] RF_W_addr;
  logic               RF_W_en;
  logic [RADDR_W-1:0] RF_Ra_addr;
  logic [RADDR_W-1:0] RF_Rb_addr;
  logic [2:0]         ALU_s0;
  logic [3:0]         state_out;
  logic               halted;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out, halted
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out, halted
  );

endinterface

// File: rtl/fetch_exec_controller_instr_field_decode.sv
// Splits the latched instruction word into opcode and raw operand fields;
// the FSM decides which fields are actually driven out.
module fetch_exec_controller_instr_field_decode
  import fetch_exec_controller_pkg::*;
(
  input  logic [IR_W-1:0]    ir_i,
  output opcode_e            opcode_o,
  output logic [RADDR_W-1:0] ra_o,
  output logic [RADDR_W-1:0] rb_o,
  output logic [RADDR_W-1:0] rw_o,
  output logic [DADDR_W-1:0] ld_addr_o,
  output logic [DADDR_W-1:0] st_addr_o
);

  assign opcode_o  = to_opcode(ir_i[OPC_LSB +: 4]);
  assign ra_o      = ir_i[RA_LSB +: RADDR_W];
  assign rb_o      = ir_i[RB_LSB +: RADDR_W];
  assign rw_o      = ir_i[RW_LSB +: RADDR_W];
  assign ld_addr_o = ir_i[LD_ADDR_LSB +: DADDR_W];
  assign st_addr_o = ir_i[ST_ADDR_LSB +: DADDR_W];

endmodule

// File: rtl/fetch_exec_controller.sv
// Fetch/decode/execute sequencer: drives the PC/IR fetch path and decodes
// each instruction into Moore-style register-file, memory and ALU strobes.
module fetch_exec_controller
  import fetch_exec_controller_pkg::*;
(
  input logic                     Clock,
  input logic                     Clr,
  fetch_exec_controller_if.master bus
);

  state_e                state_q, state_d;
  opcode_e               opcode;
  logic [RADDR_W-1:0]    ra, rb, rw;
  logic [DADDR_W-1:0]    ld_addr, st_addr;

  fetch_exec_controller_instr_field_decode u_decode (
    .ir_i      (bus.IR),
    .opcode_o  (opcode),
    .ra_o      (ra),
    .rb_o      (rb),
    .rw_o      (rw),
    .ld_addr_o (ld_addr),
    .st_addr_o (st_addr)
  );

  always_ff @(posedge Clock) begin
    if (Clr) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_PRIME;
      S_PRIME:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:  state_d = S_LOAD_A;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      // Unused encodings restart the sequence rather than lock up.
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_s0     = ALU_PASS;
    bus.halted     = 1'b0;
    case (state_q)
      S_INIT:  bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        bus.D_addr    = ld_addr;
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = rw;
        bus.RF_W_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        bus.D_addr     = st_addr;
        bus.RF_Ra_addr = ra;
        bus.D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = ra;
        bus.RF_Rb_addr = rb;
        bus.RF_W_addr  = rw;
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_out = state_q;

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Bench: a small ROM/PC/IR model feeds the controller; each program is
// expanded instruction-by-instruction into the expected per-cycle outputs.
module tb_fetch_exec_controller;

  logic Clock = 1'b0;
  logic Clr   = 1'b1;
  always #5 Clock = ~Clock;

  fetch_exec_controller_if bus ();

  fetch_exec_controller dut (
    .Clock (Clock),
    .Clr   (Clr),
    .bus   (bus)
  );

  // Fetch datapath stand-in: ROM, PC and instruction register.
  logic [15:0] rom [64];
  int          pc_m = 0;
  logic [15:0] ir_q = 16'h0000;
  assign bus.IR = ir_q;

  always @(posedge Clock) begin
    if (bus.PC_clr)     pc_m <= 0;
    else if (bus.PC_up) pc_m <= pc_m + 1;
    if (bus.IR_ld)      ir_q <= rom[pc_m % 64];
  end

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rw;
    logic       rw_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } rec_t;

  rec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rec_t blank(input int st);
    rec_t r;
    r    = '0;
    r.st = st[3:0];
    return r;
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.st     = bus.state_out;
    r.pc_clr = bus.PC_clr;
    r.pc_up  = bus.PC_up;
    r.ir_ld  = bus.IR_ld;
    r.d_addr = bus.D_addr;
    r.d_wr   = bus.D_wr;
    r.rf_s   = bus.RF_s;
    r.rw     = bus.RF_W_addr;
    r.rw_en  = bus.RF_W_en;
    r.ra     = bus.RF_Ra_addr;
    r.rb     = bus.RF_Rb_addr;
    r.alu    = bus.ALU_s0;
    r.halted = bus.halted;
    return r;
  endfunction

  function automatic rec_t init_rec();
    rec_t r;
    r        = blank(0);
    r.pc_clr = 1'b1;
    return r;
  endfunction

  // Cycles an instruction occupies: FETCH, DECODE, then its execute cycles.
  function automatic void push_instr(input logic [15:0] ins);
    rec_t r;
    r       = blank(2);
    r.pc_up = 1'b1;
    r.ir_ld = 1'b1;
    exp_q.push_back(r);
    exp_q.push_back(blank(3));
    case (ins[15:12])
      4'h2: begin
        r        = blank(5);
        r.d_addr = ins[11:4];
        r.rf_s   = 1'b1;
        r.rw     = ins[3:0];
        exp_q.push_back(r);
        r.st     = 4'd6;
        r.rw_en  = 1'b1;
        exp_q.push_back(r);
      end
      4'h1: begin
        r        = blank(7);
        r.ra     = ins[11:8];
        r.d_addr = ins[7:0];
        r.d_wr   = 1'b1;
        exp_q.push_back(r);
      end
      4'h3, 4'h4: begin
        r       = blank(ins[15:12] == 4'h3 ? 8 : 9);
        r.ra    = ins[11:8];
        r.rb    = ins[7:4];
        r.rw    = ins[3:0];
        r.rw_en = 1'b1;
        r.alu   = (ins[15:12] == 4'h3) ? 3'b001 : 3'b010;
        exp_q.push_back(r);
      end
      4'h5: begin
        r        = blank(10);
        r.halted = 1'b1;
        for (int k = 0; k < 11; k++) exp_q.push_back(r);
      end
      default: ;
    endcase
  endfunction

  // Runs the ROM from reset exit; abort_after>0 pulses Clr after that many cycles.
  task automatic run_prog(input string name, input int abort_after);
    int n;
    exp_q.delete();
    exp_q.push_back(blank(1));
    for (int p = 0; p < 64; p++) begin
      push_instr(rom[p]);
      if (rom[p][15:12] == 4'h5) break;
    end
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      chk($sformatf("%s_c%0d", name, n), observe(), exp_q.pop_front());
      n++;
      if (abort_after > 0 && n == abort_after) break;
    end
    Clr = 1'b1;
    @(negedge Clock);
    chk($sformatf("%s_clr", name), observe(), init_rec());
    Clr = 1'b0;
  endtask

  initial begin
    logic [15:0] rnd;
    logic [3:0]  op;
    int          len;
    for (int i = 0; i < 64; i++) rom[i] = 16'h5000;

    Clr = 1'b1;
    @(negedge Clock);
    chk("rst0", observe(), init_rec());
    @(negedge Clock);
    chk("rst1", observe(), init_rec());
    Clr = 1'b0;

    rom[0] = 16'h2A53;
    rom[1] = 16'h1307;
    rom[2] = 16'h3125;
    rom[3] = 16'h4125;
    rom[4] = 16'hF000;
    rom[5] = 16'h0000;
    rom[6] = 16'h5000;
    run_prog("directed", 0);

    rom[0] = 16'h2A53;
    run_prog("abort_load", 4);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h5) op = 4'h3;
        rnd    = 16'($urandom());
        rom[i] = {op, rnd[11:0]};
      end
      rnd      = 16'($urandom());
      rom[len] = {4'h5, rnd[11:0]};
      run_prog($sformatf("rand%0d", r), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
